uart_tx_sched: RTL

- Round-robin scheduler that shares the single UART transmitter between NREQ byte requesters.
- After reset or a cfg_load pulse, writes the baud and control registers into the UART.
- Then grants one requester at a time: writes its byte to the UART txbuf and waits for the UART TX-complete pending before the next grant.
- Sits between on-chip byte sources and the UART register write strobes (uart_baud_wr / uart_con_wr / uart_txbuf_wr / icb_wdat).

---
 rtl/uart_tx_sched_if.sv | 29 ++
 rtl/uart_tx_sched.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched_if.sv
// -----------------------------------------------------------------------------
// uart_tx_sched_if
//   Register-write side of the UART as seen by the transmit scheduler.
//   master : the scheduler (drives write strobes and data, reads pending)
//   slave  : the UART register block
// Signals
//   uart_baud_wr   baud divisor register write strobe
//   uart_con_wr    control register write strobe
//   uart_txbuf_wr  transmit buffer write strobe
//   icb_wdat[15:0] write data shared by all three strobes
//   uart_int       UART pending flag (TX complete while txie is set)
// -----------------------------------------------------------------------------
interface uart_tx_sched_if;
  logic        uart_baud_wr;
  logic        uart_con_wr;
  logic        uart_txbuf_wr;
  logic [15:0] icb_wdat;
  logic        uart_int;

  modport master (
    output uart_baud_wr, uart_con_wr, uart_txbuf_wr, icb_wdat,
    input  uart_int
  );

  modport slave (
    input  uart_baud_wr, uart_con_wr, uart_txbuf_wr, icb_wdat,
    output uart_int
  );
endinterface

// File: rtl/uart_tx_sched.sv
// -----------------------------------------------------------------------------
// uart_tx_sched
//   Round-robin scheduler sharing one UART transmitter between NREQ byte
//   sources. Initialises the UART (baud, then control with en/txie forced),
//   then grants one requester at a time: writes its byte to txbuf and waits
//   for the TX-complete pending (low, then high) before the next grant.
//
// Parameters
//   NREQ   number of requesters (2..8)
//   TMO_W  width of the TX-complete timeout counter
//
// Optional feature
//   UART_TX_SCHED_TMO_EN : when defined, a TMO_W-bit counter bounds the wait
//   for TX-complete; at all-ones tmo_err pulses and the UART is re-initialised.
//   When undefined the wait is unbounded and tmo_err is tied low.
//
// Ports
//   sys_clk, sys_rst     clock, asynchronous active-high reset
//   cfg_baud, cfg_con    init values for the UART baud / control registers
//   cfg_load             one-cycle pulse requesting a re-initialisation
//   req, req_dat         per-requester byte-valid level and byte (8 bits each)
//   ack, done            one-cycle pulses: byte written to txbuf / fully sent
//   busy                 high whenever the scheduler is not in IDLE
//   tmo_err              one-cycle pulse on TX-complete timeout
//   uart                 UART register-write interface (master side)
// -----------------------------------------------------------------------------
module uart_tx_sched #(
  parameter int NREQ  = 4,
  parameter int TMO_W = 20
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [15:0]          cfg_baud,
  input  logic [15:0]          cfg_con,
  input  logic                 cfg_load,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*8-1:0]    req_dat,
  output logic [NREQ-1:0]      ack,
  output logic [NREQ-1:0]      done,
  output logic                 busy,
  output logic                 tmo_err,
  uart_tx_sched_if.master      uart
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8 || TMO_W < 2) begin : g_param_check
    $error("uart_tx_sched: NREQ must be 2..8 and TMO_W at least 2");
  end

  typedef enum logic [2:0] {
    INIT_BAUD,
    INIT_CON,
    IDLE,
    WR_TX,
    WAIT_LO,
    WAIT_HI
  } state_t;

  state_t              r_state;
  logic [IDX_W-1:0]    r_ptr;       // last granted requester
  logic [IDX_W-1:0]    r_win;       // requester currently being served
  logic [7:0]          r_byte;
  logic                r_cfg_pend;  // cfg_load seen while a byte was in flight
  logic                r_baud_wr;
  logic                r_con_wr;
  logic                r_tx_wr;
  logic [15:0]         r_wdat;
  logic [NREQ-1:0]     r_ack;
  logic [NREQ-1:0]     r_done;
  logic                r_tmo_err;

  logic                w_found;
  logic [IDX_W-1:0]    w_win;
  logic [IDX_W-1:0]    w_cand;
  logic                w_tmo_hit;
  logic                w_waiting;

  assign w_waiting = (r_state == WAIT_LO) || (r_state == WAIT_HI);

  // Round-robin search: first set req strictly after the last winner.
  // NOTE: every variable gets a default before the loop so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_ptr;
    w_cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = IDX_W'((int'(r_ptr) + k) % NREQ);
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

`ifdef UART_TX_SCHED_TMO_EN
  logic [TMO_W-1:0] r_tmo_cnt;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)                r_tmo_cnt <= '0;
    else if (r_state == WR_TX)  r_tmo_cnt <= '0;
    else if (w_waiting)         r_tmo_cnt <= r_tmo_cnt + 1'b1;
  end

  assign w_tmo_hit = w_waiting && (&r_tmo_cnt);
`else
  assign w_tmo_hit = 1'b0;
`endif

  // Outputs are registered: each strobe is issued on the edge that leaves
  // the state owning it, so it is visible for exactly one cycle afterwards.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state    <= INIT_BAUD;
      r_ptr      <= IDX_W'(NREQ - 1);
      r_win      <= '0;
      r_byte     <= '0;
      r_cfg_pend <= 1'b0;
      r_baud_wr  <= 1'b0;
      r_con_wr   <= 1'b0;
      r_tx_wr    <= 1'b0;
      r_wdat     <= '0;
      r_ack      <= '0;
      r_done     <= '0;
      r_tmo_err  <= 1'b0;
    end else begin
      r_baud_wr <= 1'b0;
      r_con_wr  <= 1'b0;
      r_tx_wr   <= 1'b0;
      r_ack     <= '0;
      r_done    <= '0;
      r_tmo_err <= 1'b0;

      if (cfg_load && (r_state == WR_TX || w_waiting)) r_cfg_pend <= 1'b1;

      case (r_state)
        INIT_BAUD: begin
          r_baud_wr <= 1'b1;
          r_wdat    <= cfg_baud;
          r_state   <= INIT_CON;
        end
        INIT_CON: begin
          if (cfg_load) begin
            r_state <= INIT_BAUD;
          end else begin
            r_con_wr   <= 1'b1;
            r_wdat     <= cfg_con | 16'h0003;
            r_cfg_pend <= 1'b0;
            r_state    <= IDLE;
          end
        end
        IDLE: begin
          // A deferred or fresh cfg_load wins over arbitration.
          if (cfg_load || r_cfg_pend) begin
            r_cfg_pend <= 1'b0;
            r_state    <= INIT_BAUD;
          end else if (w_found) begin
            r_win   <= w_win;
            r_ptr   <= w_win;
            r_byte  <= req_dat[{w_win, 3'b000} +: 8];
            r_state <= WR_TX;
          end
        end
        WR_TX: begin
          r_tx_wr      <= 1'b1;
          r_wdat       <= {8'd0, r_byte};
          r_ack[r_win] <= 1'b1;
          r_state      <= WAIT_LO;
        end
        WAIT_LO: begin
          // The txbuf write clears pending; a still-high flag is stale.
          if (w_tmo_hit) begin
            r_tmo_err <= 1'b1;
            r_state   <= INIT_BAUD;
          end else if (!uart.uart_int) begin
            r_state <= WAIT_HI;
          end
        end
        WAIT_HI: begin
          if (w_tmo_hit) begin
            r_tmo_err <= 1'b1;
            r_state   <= INIT_BAUD;
          end else if (uart.uart_int) begin
            r_done[r_win] <= 1'b1;
            r_state       <= IDLE;
          end
        end
        default: r_state <= INIT_BAUD;
      endcase
    end
  end

  assign ack                = r_ack;
  assign done               = r_done;
  assign tmo_err            = r_tmo_err;
  assign busy               = (r_state != IDLE);
  assign uart.uart_baud_wr  = r_baud_wr;
  assign uart.uart_con_wr   = r_con_wr;
  assign uart.uart_txbuf_wr = r_tx_wr;
  assign uart.icb_wdat      = r_wdat;

endmodule
